// File: rtl/load_store_unit.sv
// load_store_unit
// Bridges the execute stage to a word-only data memory. Byte, halfword and
// word loads/stores are accepted on a valid/ready handshake. Loads return
// sign- or zero-extended data. Sub-word stores use read-modify-write.
// Requests that are misaligned, out of range or illegal are answered with
// resp_error and never reach the memory.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             request handshake: write flag, funct3 size code,
//                     byte address, store data
//   resp_*            one-cycle completion pulse with error flag and load data
//   memRead/memWrite  memory strobes (never high together)
//   address           word index into the 127-word memory
//   writeData         word driven to memory during a write
//   readData          word returned by memory during a read
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        memRead,
    output logic        memWrite,
    output logic [6:0]  address,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [8:0]  addr_r;
    logic [2:0]  funct3_r;
    logic        write_r;
    logic        err_r;
    logic [31:0] wdata_r;
    logic [31:0] word_r;
    logic        accept_s;
    logic        reject_s;

    // A request is rejected for an illegal size code, bad alignment, address
    // bits above the memory window, or the non-existent word index 127.
    function automatic logic req_reject(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] a);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a[1:0] != 2'b00);
            3'b100:  bad = wr;
            3'b101:  bad = wr | a[0];
            default: bad = 1'b1;
        endcase
        bad = bad | (a[31:9] != 23'd0) | (a[8:2] == 7'd127);
        return bad;
    endfunction

    // Select the addressed lane of a word and extend it per the size code.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0] lane,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'd0;
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Overlay store data onto the previously read word; SW passes data through.
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [1:0] lane,
                                                input logic [2:0] f3,
                                                input logic [31:0] d);
        logic [31:0] m;
        m = w;
        case (f3)
            3'b000: begin
                case (lane)
                    2'd0:    m[7:0]   = d[7:0];
                    2'd1:    m[15:8]  = d[7:0];
                    2'd2:    m[23:16] = d[7:0];
                    2'd3:    m[31:24] = d[7:0];
                    default: m = w;
                endcase
            end
            3'b001: begin
                if (lane[1]) begin
                    m[31:16] = d[15:0];
                end else begin
                    m[15:0] = d[15:0];
                end
            end
            3'b010:  m = d;
            default: m = w;
        endcase
        return m;
    endfunction

    assign req_ready = rst_n && (state_r == ST_IDLE);
    assign accept_s  = req_valid && req_ready;
    assign reject_s  = req_reject(req_write, req_funct3, req_addr);

    // State register and request/read-word capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            addr_r   <= 9'd0;
            funct3_r <= 3'd0;
            write_r  <= 1'b0;
            err_r    <= 1'b0;
            wdata_r  <= 32'd0;
            word_r   <= 32'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                addr_r   <= req_addr[8:0];
                funct3_r <= req_funct3;
                write_r  <= req_write;
                err_r    <= reject_s;
                wdata_r  <= req_wdata;
            end
            if (state_r == ST_READ) begin
                word_r <= readData;
            end
        end
    end

    // Next-state sequencing: loads and sub-word stores read first, SW writes
    // directly, rejected requests go straight to the response.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_s = ST_IDLE;
                end else if (reject_s) begin
                    state_s = ST_RESP;
                end else if (req_write && (req_funct3 == 3'b010)) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_READ:  state_s = write_r ? ST_WRITE : ST_RESP;
            ST_WRITE: state_s = ST_RESP;
            ST_RESP:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Moore output decode; everything idles at zero outside its own state.
    always_comb begin
        memRead    = 1'b0;
        memWrite   = 1'b0;
        address    = 7'd0;
        writeData  = 32'd0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        resp_rdata = 32'd0;
        case (state_r)
            ST_READ: begin
                memRead = 1'b1;
                address = addr_r[8:2];
            end
            ST_WRITE: begin
                memWrite  = 1'b1;
                address   = addr_r[8:2];
                writeData = store_merge(word_r, addr_r[1:0], funct3_r, wdata_r);
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_error = err_r;
                if (err_r || write_r) begin
                    resp_rdata = 32'd0;
                end else begin
                    resp_rdata = load_extract(word_r, addr_r[1:0], funct3_r);
                end
            end
            default: begin
                memRead = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        memRead;
    logic        memWrite;
    logic [6:0]  address;
    logic [31:0] writeData;
    logic [31:0] readData;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .memRead(memRead), .memWrite(memWrite), .address(address),
        .writeData(writeData), .readData(readData)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [31:0] v;
        v = 32'h1000_0000 + i * 32'h0101_0101;
        if (i == 3) v = 32'h8765_4321;
        return v;
    endfunction

    // ---------------- memory attached to the DUT ----------------
    logic [31:0] mem [0:126];
    bit mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 127; i++) mem[i] <= pat(i);
            mem_loaded <= 1'b1;
        end else if (memWrite) begin
            mem[address] <= writeData;
        end
    end
    always @(negedge clk) begin
        if (memRead) readData <= mem[address];
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdat;
        logic        rv;
        logic        re;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [0:126];
    bit          ref_loaded = 1'b0;

    function automatic bit m_reject(input bit wr, input bit [2:0] f, input bit [31:0] a);
        int size;
        bit legal;
        legal = (f == 3'd0 || f == 3'd1 || f == 3'd2) || (!wr && (f == 3'd4 || f == 3'd5));
        if (!legal) return 1'b1;
        size = 1 << (f % 4);
        if (a % size != 0) return 1'b1;
        if (a >= 32'd512) return 1'b1;
        if (a / 4 == 127) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_mask(input bit [2:0] f);
        logic [31:0] m;
        m = (f % 4 == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
        return m;
    endfunction

    function automatic int m_shift(input bit [2:0] f, input bit [31:0] a);
        return (f % 4 == 0) ? 8 * (a % 4) : 16 * ((a % 4) / 2);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input bit [2:0] f, input bit [31:0] a);
        logic [31:0] v;
        if (f == 3'd2) return w;
        v = (w >> m_shift(f, a)) & m_mask(f);
        if (f == 3'd0 && v[7])  v = v | ~m_mask(f);
        if (f == 3'd1 && v[15]) v = v | ~m_mask(f);
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input bit [2:0] f,
                                            input bit [31:0] a, input logic [31:0] d);
        if (f == 3'd2) return d;
        return (w & ~(m_mask(f) << m_shift(f, a))) | ((d & m_mask(f)) << m_shift(f, a));
    endfunction

    // Model: exp_q[0] describes the cycle in progress; an empty queue means idle.
    always @(posedge clk or negedge rst_n) begin
        exp_t cur;
        exp_t r;
        bit   was_idle;
        bit [6:0] idx;
        if (!rst_n) begin
            exp_q.delete();
            if (!ref_loaded) begin
                for (int i = 0; i < 127; i++) ref_mem[i] = pat(i);
                ref_loaded = 1'b1;
            end
        end else begin
            was_idle = (exp_q.size() == 0);
            if (!was_idle) begin
                cur = exp_q.pop_front();
                if (cur.wr) ref_mem[cur.addr] = cur.wdat;
            end
            if (was_idle && req_valid) begin
                idx = 7'((req_addr / 4) % 128);
                if (m_reject(req_write, req_funct3, req_addr)) begin
                    r = '0; r.rv = 1'b1; r.re = 1'b1; exp_q.push_back(r);
                end else if (!req_write) begin
                    r = '0; r.rd = 1'b1; r.addr = idx; exp_q.push_back(r);
                    r = '0; r.rv = 1'b1;
                    r.rdata = m_load(ref_mem[idx], req_funct3, req_addr);
                    exp_q.push_back(r);
                end else begin
                    if (req_funct3 != 3'd2) begin
                        r = '0; r.rd = 1'b1; r.addr = idx; exp_q.push_back(r);
                    end
                    r = '0; r.wr = 1'b1; r.addr = idx;
                    r.wdat = m_merge(ref_mem[idx], req_funct3, req_addr, req_wdata);
                    exp_q.push_back(r);
                    r = '0; r.rv = 1'b1; exp_q.push_back(r);
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        exp_t e;
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk("req_ready", {31'd0, req_ready}, {31'd0, (rst_n && exp_q.size() == 0)});
        chk("memRead", {31'd0, memRead}, {31'd0, e.rd});
        chk("memWrite", {31'd0, memWrite}, {31'd0, e.wr});
        chk("address", {25'd0, address}, {25'd0, e.addr});
        chk("writeData", writeData, e.wr ? e.wdat : 32'd0);
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, e.rv});
        chk("resp_error", {31'd0, resp_error}, {31'd0, e.re});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("strobe_overlap", {31'd0, (memRead && memWrite)}, 32'd0);
    end

    // ---------------- observation counters ----------------
    int          resp_cnt = 0, rd_cnt = 0, rd3_cnt = 0, wr_cnt = 0;
    logic [31:0] last_rdata = 32'd0, last_wdata = 32'd0;
    logic        last_err = 1'b0;
    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++;
            last_rdata = resp_rdata;
            last_err = resp_error;
        end
        if (memRead) rd_cnt++;
        if (memRead && address == 7'd3) rd3_cnt++;
        if (memWrite) begin
            wr_cnt++;
            last_wdata = writeData;
        end
    end

    int cyc = 0;
    int acc_cyc[$];
    always @(posedge clk) begin
        if (req_valid && req_ready) acc_cyc.push_back(cyc);
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit wr, input bit [2:0] f, input bit [31:0] a, input bit [31:0] d);
        int n;
        int rc0;
        rc0 = resp_cnt;
        @(negedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_funct3 = f; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_timeout", {31'd0, (n >= 20)}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (resp_cnt == rc0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("resp_timeout", {31'd0, (n >= 20)}, 32'd0);
    endtask

    typedef struct { bit wr; bit [2:0] f; bit [31:0] a; bit [31:0] d; logic [31:0] exp; } vec_t;

    initial begin
        vec_t loads[5];
        vec_t errs[5];
        int r0, w0, a0, n;

        loads[0] = '{1'b0, 3'd0, 32'h0F, 32'd0, 32'hFFFF_FF87};
        loads[1] = '{1'b0, 3'd4, 32'h0F, 32'd0, 32'h0000_0087};
        loads[2] = '{1'b0, 3'd1, 32'h0E, 32'd0, 32'hFFFF_8765};
        loads[3] = '{1'b0, 3'd5, 32'h0C, 32'd0, 32'h0000_4321};
        loads[4] = '{1'b0, 3'd2, 32'h0C, 32'd0, 32'h8765_4321};
        errs[0]  = '{1'b0, 3'd2, 32'h006, 32'd0, 32'd0};
        errs[1]  = '{1'b1, 3'd1, 32'h00B, 32'h1234, 32'd0};
        errs[2]  = '{1'b1, 3'd2, 32'h1FC, 32'hDEAD_BEEF, 32'd0};
        errs[3]  = '{1'b1, 3'd4, 32'h00C, 32'h55, 32'd0};
        errs[4]  = '{1'b0, 3'd2, 32'h200, 32'd0, 32'd0};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_memRead", {31'd0, memRead}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        foreach (loads[i]) begin
            r0 = rd3_cnt;
            send(loads[i].wr, loads[i].f, loads[i].a, loads[i].d);
            chk($sformatf("load%0d_rdata", i), last_rdata, loads[i].exp);
            chk($sformatf("load%0d_err", i), {31'd0, last_err}, 32'd0);
            chk($sformatf("load%0d_reads", i), 32'(rd3_cnt - r0), 32'd1);
        end

        w0 = wr_cnt;
        r0 = rd_cnt;
        send(1'b1, 3'd0, 32'h0D, 32'h0000_00AA);
        chk("sb_writes", 32'(wr_cnt - w0), 32'd1);
        chk("sb_reads", 32'(rd_cnt - r0), 32'd1);
        chk("sb_wdata", last_wdata, 32'h8765_AA21);
        chk("sb_rdata", last_rdata, 32'd0);
        send(1'b0, 3'd2, 32'h0C, 32'd0);
        chk("lw_after_sb", last_rdata, 32'h8765_AA21);

        foreach (errs[i]) begin
            r0 = rd_cnt;
            w0 = wr_cnt;
            send(errs[i].wr, errs[i].f, errs[i].a, errs[i].d);
            chk($sformatf("err%0d_flag", i), {31'd0, last_err}, 32'd1);
            chk($sformatf("err%0d_rdata", i), last_rdata, 32'd0);
            chk($sformatf("err%0d_strobes", i), 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
        end

        // Reset in the middle of an SH read-modify-write.
        w0 = wr_cnt;
        @(negedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1; req_addr = 32'h0C; req_wdata = 32'hBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sh_in_read", {31'd0, memRead}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_memRead", {31'd0, memRead}, 32'd0);
        chk("rst_mid_address", {25'd0, address}, 32'd0);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_mid_resp", {30'd0, resp_valid, resp_error}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("rst_word3", mem[3], 32'h8765_AA21);

        // Back-to-back SW stream with req_valid held high.
        w0 = wr_cnt;
        a0 = acc_cyc.size();
        @(negedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        for (int k = 0; k < 4; k++) begin
            req_addr = 32'h40 + 32'(4 * k);
            req_wdata = 32'h1111_1111 * 32'(k + 1);
            n = 0;
            while (!req_ready && n < 10) begin
                @(negedge clk); #1; n++;
            end
            chk("b2b_accept_timeout", {31'd0, (n >= 10)}, 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("b2b_writes", 32'(wr_cnt - w0), 32'd4);
        chk("b2b_accepts", 32'(acc_cyc.size() - a0), 32'd4);
        if (acc_cyc.size() - a0 == 4) begin
            for (int k = 1; k < 4; k++)
                chk($sformatf("b2b_spacing%0d", k), 32'(acc_cyc[a0 + k] - acc_cyc[a0 + k - 1]), 32'd3);
        end
        send(1'b0, 3'd2, 32'h44, 32'd0);
        chk("b2b_readback1", last_rdata, 32'h2222_2222);
        send(1'b0, 3'd2, 32'h4C, 32'd0);
        chk("b2b_readback3", last_rdata, 32'h4444_4444);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side bridge between the core's execute stage and the word-only data memory. Accepts byte-addressed loads and stores of byte, halfword or word width, drives the memory's memRead/memWrite/address/writeData strobes, and returns sign- or zero-extended load data. Sub-word stores use an internal read-modify-write sequence. Misaligned, out-of-range or illegal requests are rejected without touching memory.

## Interface
- No parameters. Memory depth is fixed at 127 words, word indices 0–126.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE with rst_n high. Handshake is req_valid && req_ready at a posedge.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size/sign code:
  - 000 = LB/SB, 001 = LH/SH, 010 = LW/SW, 100 = LBU, 101 = LHU.
  - 100/101 are legal for loads only.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data. Low byte/halfword are used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse. No backpressure.
- resp_error  out  1  qualifies resp_valid: misaligned, out-of-range or illegal access.
- resp_rdata  out  32  load result. 0 for stores and errors.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- address  out  7  word index, req_addr[8:2].
- writeData  out  32  word written to memory.
- readData  in  32  memory read data. Memory captures it on the falling edge while memRead is high.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Request register: on handshake, latch addr[8:0], funct3, write and wdata.
- Rejection, checked at accept time:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - req_addr[31:9]≠0;
  - word index 127;
  - illegal funct3.
  - Rejected requests go to RESP with resp_error=1. No memRead/memWrite is ever asserted for them.
- Transitions:
  - Load: IDLE→READ→RESP→IDLE.
  - SW: IDLE→WRITE→RESP→IDLE.
  - SB/SH: IDLE→READ→WRITE→RESP→IDLE.
- Strobes (Moore outputs, decoded from state):
  - READ: memRead=1.
  - WRITE: memWrite=1.
  - READ/WRITE: address = latched word index.
  - All other states: strobes 0 and address 0.
- READ exit: latch readData into a word register at the posedge that leaves READ.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- SB/SH merge: replace lane bits in the latched word with wdata[7:0] / wdata[15:0]; all other bits are preserved.
- SW: writeData = wdata, with no read.
- Reset (any state): return to IDLE immediately.
  - All outputs go to 0, req_ready included.
  - Any in-flight access is dropped. A sub-word store reset before WRITE leaves memory unchanged.

## Timing
- Handshake at posedge T.
- Load: memRead high T→T+1. Data is sampled at T+1. resp_valid high T+1→T+2.
- SW: memWrite high T→T+1. Memory commits at T+1. resp_valid high T+1→T+2.
- SB/SH: READ T→T+1, WRITE T+1→T+2, resp_valid high T+2→T+3.
- Error: resp_valid and resp_error high T→T+1, with no strobe.
- resp_rdata and resp_error are valid only while resp_valid=1, and 0 otherwise.
- req_ready drops the cycle after a handshake and returns in the cycle after RESP. Back-to-back throughput is one request every 3 cycles for loads and SW, 4 cycles for SB/SH.
- memRead and memWrite are never high in the same cycle.

## Test plan
- Word 3 = 0x87654321; LB addr 0x0F → resp_rdata 0xFFFFFF87. LBU addr 0x0F → 0x00000087.
- LH addr 0x0E → 0xFFFF8765. LHU addr 0x0C → 0x00004321. LW addr 0x0C → 0x87654321. Each load shows exactly one memRead cycle with address=3.
- SB addr 0x0D, wdata 0x000000AA → memRead then memWrite with writeData 0x8765AA21. A following LW returns 0x8765AA21.
- LW addr 0x06, SH addr 0x0B, SW addr 0x1FC (index 127), LBU-coded store → each gives resp_error=1, resp_rdata=0, and no strobe.
- Assert rst_n low during READ of an SH to addr 0x0C → all outputs 0 at once, no memWrite follows, and word 3 is unchanged.
- Hold req_valid high with SW to 4 consecutive addresses → accepts spaced 3 cycles apart, one memWrite pulse each, strobes never overlap.
